// File: rtl/sync_cntr_pkg.sv
// Shared constants for the synchronous T-flip-flop up-counter.
package sync_cntr_pkg;

    localparam int unsigned CNTR_WIDTH_DEFAULT = 3;
    localparam int unsigned CNTR_WIDTH_MIN     = 1;
    localparam int unsigned CNTR_WIDTH_MAX     = 16;

endpackage : sync_cntr_pkg

// File: rtl/sync_cntr_if.sv
// Count output bundle: the counter drives q, consumers observe it.
interface sync_cntr_if
    import sync_cntr_pkg::*;
#(
    parameter int unsigned WIDTH = CNTR_WIDTH_DEFAULT
) ();

    logic [WIDTH-1:0] q;

    modport master (output q);
    modport slave  (input  q);

endinterface : sync_cntr_if

// File: rtl/sync_cntr_tff.sv
// Single T flip-flop with synchronous active-high clear; toggles when t is high.
module sync_cntr_tff (
    input  logic clk,
    input  logic clear,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q ^ t;
    end

    // Clear wins over toggle on every edge.
    always_ff @(posedge clk) begin
        if (clear) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : sync_cntr_tff

// File: rtl/sync_cntr.sv
// Free-running synchronous binary up-counter built from a chain of T flip-flops.
module sync_cntr
    import sync_cntr_pkg::*;
#(
    parameter int unsigned WIDTH = CNTR_WIDTH_DEFAULT
) (
    input  logic              clear,
    input  logic              clk,
    sync_cntr_if.master       cnt_if
);

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] tog_c;

    // Bit i toggles when all lower bits are one; bit 0 toggles every edge.
    assign tog_c[0] = 1'b1;

    for (genvar i = 1; i < int'(WIDTH); i++) begin : g_tog
        assign tog_c[i] = tog_c[i-1] & q_w[i-1];
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_tff
        sync_cntr_tff u_tff (
            .clk   (clk),
            .clear (clear),
            .t     (tog_c[i]),
            .q     (q_w[i])
        );
    end

    assign cnt_if.q = q_w;

endmodule : sync_cntr

// File: tb/tb_sync_cntr.sv
// Directed scoreboard bench for sync_cntr at WIDTH = 3 and WIDTH = 4.
module tb_sync_cntr;

    logic clk;
    logic clear3;
    logic clear4;

    int unsigned pass_cnt;
    int unsigned total_cnt;

    logic [2:0] exp3_q[$];
    logic [3:0] exp4_q[$];
    logic [2:0] model3;
    logic [3:0] model4;

    sync_cntr_if #(.WIDTH(3)) if3 ();
    sync_cntr_if #(.WIDTH(4)) if4 ();

    sync_cntr #(.WIDTH(3)) u_dut3 (
        .clear  (clear3),
        .clk    (clk),
        .cnt_if (if3.master)
    );

    sync_cntr #(.WIDTH(4)) u_dut4 (
        .clear  (clear4),
        .clk    (clk),
        .cnt_if (if4.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive clear for the WIDTH=3 counter across one edge and score the result.
    task automatic step3(input string tag, input logic c);
        logic [2:0] e;
        clear3 = c;
        model3 = c ? 3'd0 : 3'(model3 + 3'd1);
        exp3_q.push_back(model3);
        @(posedge clk);
        #1;
        e = exp3_q.pop_front();
        check3(tag, if3.q, e);
    endtask

    task automatic step4(input string tag, input logic c);
        logic [3:0] e;
        logic [3:0] prev;
        logic       exp_tog;
        prev    = model4;
        clear4  = c;
        model4  = c ? 4'd0 : 4'(model4 + 4'd1);
        exp_tog = !c && (prev == 4'd7 || prev == 4'd15);
        exp4_q.push_back(model4);
        @(posedge clk);
        #1;
        e = exp4_q.pop_front();
        check4(tag, if4.q, e);
        if (!c) begin
            check4({tag, "_bit3_toggle"}, 4'(prev[3] ^ if4.q[3]), 4'(exp_tog));
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        model3    = '0;
        model4    = '0;
        clear3    = 1'b1;
        clear4    = 1'b1;
        #1;

        // Power-up clear held for two edges.
        step3("pwr_clear_e1", 1'b1);
        step3("pwr_clear_e2", 1'b1);

        // Full count with wrap: 1..7,0,1.
        for (int i = 0; i < 9; i++) step3("count_wrap", 1'b0);

        // Mid-count clear at q=5, then resume.
        for (int i = 0; i < 4; i++) step3("to_five", 1'b0);
        step3("mid_clear", 1'b1);
        step3("mid_release_1", 1'b0);
        step3("mid_release_2", 1'b0);

        // Clear pulse entirely between edges at q=3 is ignored.
        step3("to_three", 1'b0);
        #2 clear3 = 1'b1;
        #2 clear3 = 1'b0;
        #1;
        check3("between_edges_hold", if3.q, 3'd3);
        step3("between_edges_next", 1'b0);

        // Clear at terminal count, held for three edges.
        for (int i = 0; i < 3; i++) step3("to_seven", 1'b0);
        check3("at_terminal", if3.q, 3'd7);
        for (int i = 0; i < 3; i++) step3("term_clear_hold", 1'b1);
        step3("term_release", 1'b0);

        // WIDTH=4: clear, then 16 edges counting 1..15,0.
        step4("w4_clear", 1'b1);
        for (int i = 0; i < 16; i++) step4("w4_count", 1'b0);
        step4("w4_after_wrap", 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_sync_cntr

// File: doc/sync_cntr.md
Name: sync_cntr

Overview:
- Synchronous binary up-counter, WIDTH bits (3 by default), built as a chain of T flip-flops sharing one clock.
- Counts 0 to 2^WIDTH-1, then wraps to 0, advancing by one on every rising clock edge.
- Synchronous clear sets it to 0.
- Leaf block used as a free-running cycle/sequence counter.

Parameters:
- WIDTH, 3, number of counter bits (legal range 1..16).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- clear  input  1  synchronous, active-high reset; forces q to 0.
- q  output  WIDTH  current count, unsigned, driven directly from flip-flops.
- Declaration order for positional instantiation: clear, clk, q.

Behaviour:
- Interface: one clock (clk). Reset (clear) is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset value: q = 0 on the first rising edge where clear = 1.
- Before the first clocked clear, q is undefined. Benches must hold clear across at least one rising edge.
- Counting: each rising edge with clear = 0 gives q_next = (q + 1) mod 2^WIDTH.
- Latency: one cycle. q changes only on rising edges, with no combinational path from inputs to q.
- Structure: WIDTH T flip-flops.
  - Toggle input of bit 0 is tied to 1.
  - Toggle input of bit i is the AND of q[i-1:0].
  - All flip-flops are clocked by clk. No ripple clocking and no derived clocks.
- Wrap-around: q = all-ones followed by a rising edge with clear = 0 gives q = 0. No carry or terminal-count output.
- Clear priority: clear = 1 overrides counting on any edge, from any state.
- Clear held: q stays 0 for every edge that clear remains high.
- Clear release: first edge with clear = 0 gives q = 1, then counting continues normally.
- Reset mid-operation: clear asserted at an arbitrary count gives q = 0 at the next rising edge. No partial update.
- Changes to clear between rising edges have no effect on q.
- No enable, load, or down-count. Counting is unconditional while clear is low.

Decomposition:
- Shared package: constant CNTR_WIDTH_DEFAULT = 3, used as the WIDTH default.
- No typedefs are required.
- One sub-module is natural: sync_cntr_tff.
  - Ports: clk, clear, t, q.
  - Behaviour: synchronous active-high clear to 0, toggle when t = 1, otherwise hold.
- Top level instantiates WIDTH copies of sync_cntr_tff in a generate loop, plus the AND chain for the toggle enables.

Test Plan:
- Power-up clear: clear = 1 for 2 rising edges -> q = 0 after the first edge and still 0 after the second.
- Full count and wrap (WIDTH = 3): clear released, 9 rising edges -> q sequence 1,2,3,4,5,6,7,0,1.
- Mid-count clear: count to q = 5, assert clear for 1 edge -> q = 0, then release -> q = 1, 2 on following edges.
- Clear between edges: pulse clear high and low entirely between two rising edges while q = 3 -> next edge gives q = 4.
- Clear at terminal count: assert clear when q = 7 -> q = 0 next edge, held at 0 while clear stays high for 3 edges.
- Parameter check: WIDTH = 4, 16 edges after clear release -> q counts 1..15 then 0. Bit 3 toggles only on the 7->8 and 15->0 transitions.
